// File: rtl/spu_preload_sequencer.sv
// Boot-time preload sequencer: parses a header/payload word stream and writes
// SPU instruction memory, register file and local store while holding the core in reset.
module spu_preload_sequencer #(
    parameter int WORD_W  = 32,
    parameter int DATA_W  = 128,
    parameter int IMEM_AW = 10,
    parameter int RF_AW   = 7,
    parameter int LS_AW   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 restart,
    output logic                 load_en,
    output logic [IMEM_AW-1:0]   instr_load_addr,
    output logic [WORD_W-1:0]    instruction_in,
    output logic                 preload_en,
    output logic [RF_AW-1:0]     preload_addr,
    output logic [DATA_W-1:0]    preload_values,
    output logic                 preload_LS_en,
    output logic [LS_AW-1:0]     preload_LS_addr,
    output logic [DATA_W-1:0]    preload_LS_data,
    output logic                 core_rst,
    output logic                 done,
    output logic                 err
);

    localparam int BEATS = DATA_W / WORD_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] T_IMEM = 2'b00;
    localparam logic [1:0] T_RF   = 2'b01;
    localparam logic [1:0] T_END  = 2'b11;

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DONE, S_ERR} state_t;

    state_t            state, next_state;
    logic [1:0]        tgt;
    logic [14:0]       addr;
    logic [14:0]       remaining;
    logic [BW-1:0]     beat;
    logic [DATA_W-1:0] pack;
    logic [DATA_W-1:0] pack_next;
    logic              accept;
    logic              last_beat;
    logic              entry_done;
    logic [1:0]        hdr_tgt;
    logic [14:0]       hdr_base;
    logic [14:0]       hdr_cnt;

    function automatic logic [14:0] aw_mask(input int aw);
        logic [15:0] m;
        m = (16'd1 << aw) - 16'd1;
        return m[14:0];
    endfunction

    function automatic logic [14:0] target_mask(input logic [1:0] t);
        case (t)
            2'b00:   return aw_mask(IMEM_AW);
            2'b01:   return aw_mask(RF_AW);
            2'b10:   return aw_mask(LS_AW);
            default: return 15'h7fff;
        endcase
    endfunction

    // Header bit 0 is the stream MSB, so the fields read from the top down.
    assign hdr_tgt  = in_data[WORD_W-1 -: 2];
    assign hdr_base = in_data[WORD_W-3 -: 15];
    assign hdr_cnt  = in_data[WORD_W-18 -: 15];

    assign in_ready   = (state == S_HDR) || (state == S_PAY);
    assign accept     = in_valid && in_ready;
    assign last_beat  = (beat == BW'(BEATS - 1));
    assign entry_done = accept && (state == S_PAY) && ((tgt == T_IMEM) || last_beat);
    assign pack_next  = (pack << WORD_W) | DATA_W'(in_data);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HDR: begin
                if (accept) begin
                    if (hdr_tgt == T_END)
                        next_state = S_DONE;
                    else if ((hdr_base & ~target_mask(hdr_tgt)) != 15'd0)
                        next_state = S_ERR;
                    else if (hdr_cnt != 15'd0)
                        next_state = S_PAY;
                end
            end
            S_PAY:   if (entry_done && remaining == 15'd1) next_state = S_HDR;
            S_DONE,
            S_ERR:   if (restart) next_state = S_HDR;
            default: next_state = S_HDR;
        endcase
    end

    // core_rst releases only after one full cycle in DONE and returns with restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt             <= T_IMEM;
            addr            <= '0;
            remaining       <= '0;
            beat            <= '0;
            pack            <= '0;
            load_en         <= 1'b0;
            instr_load_addr <= '0;
            instruction_in  <= '0;
            preload_en      <= 1'b0;
            preload_addr    <= '0;
            preload_values  <= '0;
            preload_LS_en   <= 1'b0;
            preload_LS_addr <= '0;
            preload_LS_data <= '0;
            core_rst        <= 1'b1;
        end else begin
            load_en       <= 1'b0;
            preload_en    <= 1'b0;
            preload_LS_en <= 1'b0;
            core_rst      <= !((state == S_DONE) && (next_state == S_DONE));
            if (state == S_HDR && next_state == S_PAY) begin
                tgt       <= hdr_tgt;
                addr      <= hdr_base;
                remaining <= hdr_cnt;
                beat      <= '0;
            end else if (state == S_PAY && accept) begin
                if (entry_done) begin
                    addr      <= (addr + 15'd1) & target_mask(tgt);
                    remaining <= remaining - 15'd1;
                end
                if (tgt == T_IMEM) begin
                    load_en         <= 1'b1;
                    instr_load_addr <= addr[IMEM_AW-1:0];
                    instruction_in  <= in_data;
                end else if (last_beat) begin
                    beat <= '0;
                    pack <= '0;
                    if (tgt == T_RF) begin
                        preload_en     <= 1'b1;
                        preload_addr   <= addr[RF_AW-1:0];
                        preload_values <= pack_next;
                    end else begin
                        preload_LS_en   <= 1'b1;
                        preload_LS_addr <= addr[LS_AW-1:0];
                        preload_LS_data <= pack_next;
                    end
                end else begin
                    beat <= beat + BW'(1);
                    pack <= pack_next;
                end
            end else if ((state == S_DONE || state == S_ERR) && restart) begin
                beat <= '0;
                pack <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spu_preload_sequencer.sv
// Scoreboard bench for spu_preload_sequencer: expected writes are queued as the
// stream is driven and matched against the DUT's write pulses.
module tb_spu_preload_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         restart;
    logic         load_en;
    logic [9:0]   instr_load_addr;
    logic [31:0]  instruction_in;
    logic         preload_en;
    logic [6:0]   preload_addr;
    logic [127:0] preload_values;
    logic         preload_LS_en;
    logic [14:0]  preload_LS_addr;
    logic [127:0] preload_LS_data;
    logic         core_rst;
    logic         done;
    logic         err;

    typedef struct {
        logic [1:0]   kind;
        logic [14:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  write_cycles[$];
    int  cycle = 0;
    int  tests_run = 0;
    int  tests_failed = 0;

    spu_preload_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .restart(restart), .load_en(load_en), .instr_load_addr(instr_load_addr),
        .instruction_in(instruction_in), .preload_en(preload_en), .preload_addr(preload_addr),
        .preload_values(preload_values), .preload_LS_en(preload_LS_en),
        .preload_LS_addr(preload_LS_addr), .preload_LS_data(preload_LS_data),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        int n;
        wr_t got, exp_wr;
        if (!rst) begin
            n = int'(load_en) + int'(preload_en) + int'(preload_LS_en);
            if (n > 1) checkOutput("one_enable", n, 1);
            if (n > 0) begin
                got.kind = load_en ? 2'd0 : (preload_en ? 2'd1 : 2'd2);
                got.addr = load_en ? 15'(instr_load_addr) : (preload_en ? 15'(preload_addr) : preload_LS_addr);
                got.data = load_en ? 128'(instruction_in) : (preload_en ? preload_values : preload_LS_data);
                write_cycles.push_back(cycle);
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    exp_wr = sb_q.pop_front();
                    checkOutput("wr_kind", got.kind, exp_wr.kind);
                    checkOutput("wr_addr", got.addr, exp_wr.addr);
                    checkOutput("wr_data", got.data, exp_wr.data);
                end
            end
        end
    end

    task automatic expectWrite(input logic [1:0] kind, input logic [14:0] addr, input logic [127:0] data);
        wr_t w;
        w.kind = kind;
        w.addr = addr;
        w.data = data;
        sb_q.push_back(w);
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        @(negedge clk);
        checkOutput("in_ready_for_word", in_ready, 1);
        in_valid = 1'b1;
        in_data  = word;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput(tag, sb_q.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseRestart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    function automatic logic [31:0] header(input logic [1:0] t, input logic [14:0] base, input logic [14:0] cnt);
        return {t, base, cnt};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [31:0]  w;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; restart = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_core_rst", core_rst, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_enables", {load_en, preload_en, preload_LS_en}, 0);
        checkOutput("rst_preload_addr", preload_addr, 0);
        checkOutput("rst_preload_values", preload_values, 0);

        // restart outside DONE/ERR is ignored
        pulseRestart();
        checkOutput("restart_hdr_ready", in_ready, 1);
        checkOutput("restart_hdr_core_rst", core_rst, 1);

        // IMEM: three back-to-back words
        write_cycles.delete();
        applyStimulus(32'h0000_0003);
        expectWrite(2'd0, 15'd0, 128'h1111_AAAA); applyStimulus(32'h1111_AAAA);
        expectWrite(2'd0, 15'd1, 128'h2222_BBBB); applyStimulus(32'h2222_BBBB);
        expectWrite(2'd0, 15'd2, 128'h3333_CCCC); applyStimulus(32'h3333_CCCC);
        idle(3);
        drain("imem_drain");
        checkOutput("imem_pulse_count", write_cycles.size(), 3);
        if (write_cycles.size() == 3)
            checkOutput("imem_consecutive", write_cycles[2] - write_cycles[0], 2);

        // LS: two entries of four beats each
        applyStimulus(header(2'b10, 15'd1, 15'd2));
        expectWrite(2'd2, 15'd1, {4{32'h0000_0001}});
        expectWrite(2'd2, 15'd2, {4{32'h0000_0002}});
        for (int e = 1; e <= 2; e++)
            for (int b = 0; b < 4; b++) applyStimulus(32'(e));
        idle(3);
        drain("ls_drain");

        // zero-count header writes nothing; the next header still lands
        applyStimulus(header(2'b01, 15'd5, 15'd0));
        applyStimulus(header(2'b00, 15'd5, 15'd1));
        expectWrite(2'd0, 15'd5, 128'hDEAD_BEEF);
        applyStimulus(32'hDEAD_BEEF);
        idle(2);
        drain("zero_count_drain");

        // RF wrap from 127 to 0 with distinct beats, first beat in the MSBs
        applyStimulus(header(2'b01, 15'd127, 15'd2));
        for (int e = 0; e < 2; e++) begin
            d = '0;
            for (int b = 0; b < 4; b++) d = {d[95:0], 32'hA000_0000 | 32'(e << 8) | 32'(b)};
            expectWrite(2'd1, (e == 0) ? 15'd127 : 15'd0, d);
            for (int b = 0; b < 4; b++) applyStimulus(32'hA000_0000 | 32'(e << 8) | 32'(b));
        end
        idle(3);
        drain("rf_wrap_drain");

        // reset mid-entry discards the partial beats
        applyStimulus(header(2'b01, 15'd3, 15'd1));
        applyStimulus(32'hBAD0_0001);
        applyStimulus(32'hBAD0_0002);
        idle(0);
        doReset();
        @(negedge clk);
        checkOutput("midrst_preload_addr", preload_addr, 0);
        checkOutput("midrst_core_rst", core_rst, 1);
        applyStimulus(header(2'b01, 15'd9, 15'd1));
        d = '0;
        for (int b = 0; b < 4; b++) begin
            w = 32'h5000_0000 + 32'(b);
            d = {d[95:0], w};
        end
        expectWrite(2'd1, 15'd9, d);
        for (int b = 0; b < 4; b++) applyStimulus(32'h5000_0000 + 32'(b));
        idle(3);
        drain("midrst_drain");

        // address out of range for IMEM -> ERR
        applyStimulus(header(2'b00, 15'h400, 15'd1));
        @(negedge clk);
        checkOutput("err_set", err, 1);
        checkOutput("err_in_ready", in_ready, 0);
        checkOutput("err_core_rst", core_rst, 1);
        in_data = 32'h1234_5678;
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", err, 1);
        in_valid = 1'b0;
        pulseRestart();
        checkOutput("err_cleared", err, 0);
        checkOutput("err_back_ready", in_ready, 1);
        checkOutput("err_back_core_rst", core_rst, 1);

        // END -> DONE, core released a cycle later, nothing accepted
        applyStimulus(header(2'b11, 15'd0, 15'd0));
        @(negedge clk);
        checkOutput("done_set", done, 1);
        checkOutput("done_first_core_rst", core_rst, 1);
        checkOutput("done_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("done_core_rst_low", core_rst, 0);
        in_data = header(2'b00, 15'd0, 15'd1);
        repeat (4) @(negedge clk);
        checkOutput("done_held", done, 1);
        in_valid = 1'b0;
        pulseRestart();
        checkOutput("done_restart_done", done, 0);
        checkOutput("done_restart_core_rst", core_rst, 1);
        checkOutput("done_restart_ready", in_ready, 1);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
